// File: rtl/rev_mult_pkg.sv
// rev_mult_pkg: shared types and sizing helpers for the sequential
// reversible (Bennett-style) shift-add multiplier.
//   state_e      - controller states IDLE / FWD / HOLD / BWD
//   PW           - product width for the default operand width
//   prod_width() - product width (2*w) for an operand width w
//   idx_width()  - bit-index counter width for an operand width w
package rev_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        HOLD = 2'd2,
        BWD  = 2'd3
    } state_e;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned PW        = 2 * DEF_WIDTH;

    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w;
    endfunction

    // A one-bit operand still needs a one-bit counter.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/dual_rail_check.sv
// dual_rail_check: combinational rail-consistency check for one
// dual-rail operand.
//   x     in  N  true rail
//   x_not in  N  complement rail
//   ok    out 1  high when every bit pair is complementary
module dual_rail_check #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] x_not,
    output logic         ok
);

    assign ok = &(x ^ x_not);

endmodule

// File: rtl/rev_mult_seq.sv
// rev_mult_seq: radix-2 shift-add multiplier with dual-rail operands and
// product. FWD accumulates a*b over WIDTH edges, HOLD presents the product
// until acknowledged, then BWD subtracts the same partial products in
// reverse order so the accumulator returns to zero (UNCOMPUTE=1), or the
// accumulator is cleared in one edge (UNCOMPUTE=0).
//   clk, rst_n          clock, synchronous active-low reset
//   start               request, sampled only in IDLE
//   a/a_not, b/b_not    dual-rail operands (WIDTH bits)
//   p_ack               product consumed, sampled only in HOLD
//   busy                high in every state except IDLE
//   p_valid             high exactly while in HOLD
//   p/p_not             dual-rail product (2*WIDTH), all-zero outside HOLD
//   done                one-cycle pulse on return to IDLE
//   rail_err            one-cycle pulse when a start is rejected
//   uncompute_err       sticky: accumulator nonzero after BWD
module rev_mult_seq
    import rev_mult_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          UNCOMPUTE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     a_not,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     b_not,
    input  logic                 p_ack,
    output logic                 busy,
    output logic                 p_valid,
    output logic [2*WIDTH-1:0]   p,
    output logic [2*WIDTH-1:0]   p_not,
    output logic                 done,
    output logic                 rail_err,
    output logic                 uncompute_err
);

    localparam int unsigned    PROD_W   = prod_width(WIDTH);
    localparam int unsigned    IW       = idx_width(WIDTH);
    localparam logic [IW-1:0]  IDX_LAST = IW'(WIDTH - 1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                done_q, done_d;
    logic                rail_err_q, rail_err_d;
    logic                uerr_q, uerr_d;

    logic                a_ok, b_ok;
    logic [PROD_W-1:0]   addend;

    dual_rail_check #(.N(WIDTH)) u_a_chk (
        .x     (a),
        .x_not (a_not),
        .ok    (a_ok)
    );

    dual_rail_check #(.N(WIDTH)) u_b_chk (
        .x     (b),
        .x_not (b_not),
        .ok    (b_ok)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        rail_err_d = 1'b0;
        uerr_d     = uerr_q;
        addend     = PROD_W'(a_q) << idx_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (a_ok && b_ok) begin
                        a_d     = a;
                        b_d     = b;
                        idx_d   = '0;
                        uerr_d  = 1'b0;
                        state_d = FWD;
                    end else begin
                        rail_err_d = 1'b1;
                    end
                end
            end
            FWD: begin
                if (b_q[idx_q]) acc_d = acc_q + addend;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_d = HOLD;
            end
            HOLD: begin
                if (p_ack) begin
                    if (UNCOMPUTE) begin
                        idx_d   = IDX_LAST;
                        state_d = BWD;
                    end else begin
                        acc_d   = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            BWD: begin
                // Same partial products as FWD, visited high-to-low, so the
                // accumulator retraces its forward trajectory back to zero.
                if (b_q[idx_q]) acc_d = acc_q - addend;
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) begin
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (acc_d != '0) uerr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            rail_err_q <= 1'b0;
            uerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            rail_err_q <= rail_err_d;
            uerr_q     <= uerr_d;
        end
    end

    // NULL spacer: both rails read zero whenever the product is not valid.
    always_comb begin
        busy          = (state_q != IDLE);
        p_valid       = (state_q == HOLD);
        p             = p_valid ? acc_q  : '0;
        p_not         = p_valid ? ~acc_q : '0;
        done          = done_q;
        rail_err      = rail_err_q;
        uncompute_err = uerr_q;
    end

endmodule

// File: tb/tb_rev_mult_seq.sv
// Self-checking bench for rev_mult_seq: one WIDTH=8/UNCOMPUTE=1 instance and
// one WIDTH=4/UNCOMPUTE=0 instance. Expected products come from plain
// multiplication; expected timing from the phase lengths (WIDTH edges each).
module tb_rev_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        s8, ack8;
    logic [7:0]  a8, an8, b8, bn8;
    logic        busy8, pv8, done8, re8, ue8;
    logic [15:0] p8, pn8;

    logic        s4, ack4;
    logic [3:0]  a4, an4, b4, bn4;
    logic        busy4, pv4, done4, re4, ue4;
    logic [7:0]  p4, pn4;

    int n_checks = 0;
    int n_errors = 0;

    rev_mult_seq #(.WIDTH(8), .UNCOMPUTE(1'b1)) u_dut8 (
        .clk (clk), .rst_n (rst_n), .start (s8),
        .a (a8), .a_not (an8), .b (b8), .b_not (bn8), .p_ack (ack8),
        .busy (busy8), .p_valid (pv8), .p (p8), .p_not (pn8),
        .done (done8), .rail_err (re8), .uncompute_err (ue8)
    );

    rev_mult_seq #(.WIDTH(4), .UNCOMPUTE(1'b0)) u_dut4 (
        .clk (clk), .rst_n (rst_n), .start (s4),
        .a (a4), .a_not (an4), .b (b4), .b_not (bn4), .p_ack (ack4),
        .busy (busy4), .p_valid (pv4), .p (p4), .p_not (pn4),
        .done (done4), .rail_err (re4), .uncompute_err (ue4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set8(input logic [7:0] a, input logic [7:0] b);
        a8 = a; an8 = ~a; b8 = b; bn8 = ~b;
    endtask

    task automatic set4(input logic [3:0] a, input logic [3:0] b);
        a4 = a; an4 = ~a; b4 = b; bn4 = ~b;
    endtask

    // Full transaction on the 8-bit instance; returns in the done cycle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int ack_delay);
        logic [15:0] prod, prod_n;
        prod   = 16'(a) * 16'(b);
        prod_n = ~prod;
        set8(a, b);
        s8 = 1'b1; ack8 = 1'b0;
        step();
        chk("accept_busy", busy8, 1);
        chk("accept_pv", pv8, 0);
        for (int k = 1; k <= 8; k++) begin
            // operand/start/ack noise while busy must be ignored
            s8   = 1'($urandom_range(0, 1));
            ack8 = 1'($urandom_range(0, 1));
            set8(8'($urandom), 8'($urandom));
            step();
            if (k < 8) begin
                chk("fwd_pv", pv8, 0);
                chk("fwd_p_null", p8, 0);
                chk("fwd_pn_null", pn8, 0);
                chk("fwd_busy", busy8, 1);
            end else begin
                chk("hold_pv", pv8, 1);
                chk("hold_p", p8, prod);
                chk("hold_pn", pn8, prod_n);
            end
        end
        ack8 = 1'b0;
        for (int d = 0; d < ack_delay; d++) begin
            s8 = 1'($urandom_range(0, 1));
            step();
            chk("hold_stable_p", p8, prod);
            chk("hold_stable_pv", pv8, 1);
        end
        ack8 = 1'b1;
        s8   = 1'($urandom_range(0, 1));
        step();
        chk("bwd_pv", pv8, 0);
        chk("bwd_p_null", p8, 0);
        chk("bwd_pn_null", pn8, 0);
        chk("bwd_busy", busy8, 1);
        for (int k = 1; k <= 8; k++) begin
            s8   = 1'($urandom_range(0, 1));
            ack8 = 1'($urandom_range(0, 1));
            set8(8'($urandom), 8'($urandom));
            step();
            if (k < 8) begin
                chk("bwd_busy", busy8, 1);
                chk("bwd_done", done8, 0);
                chk("bwd_pn_null", pn8, 0);
            end else begin
                chk("end_done", done8, 1);
                chk("end_busy", busy8, 0);
                chk("end_pv", pv8, 0);
                chk("end_uerr", ue8, 0);
                chk("end_p_null", p8, 0);
            end
        end
        s8 = 1'b0; ack8 = 1'b0;
    endtask

    task automatic rail8(input logic [7:0] a, input logic [7:0] a_n,
                         input logic [7:0] b, input logic [7:0] b_n);
        a8 = a; an8 = a_n; b8 = b; bn8 = b_n;
        s8 = 1'b1;
        step();
        s8 = 1'b0;
        chk("rail_err_pulse", re8, 1);
        chk("rail_busy", busy8, 0);
        chk("rail_pv", pv8, 0);
        step();
        chk("rail_err_clear", re8, 0);
        chk("rail_busy2", busy8, 0);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] prod, prod_n;
        prod   = 8'(a) * 8'(b);
        prod_n = ~prod;
        set4(a, b);
        s4 = 1'b1;
        step();
        s4 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) begin
                chk("w4_fwd_pv", pv4, 0);
                chk("w4_fwd_p_null", p4, 0);
            end else begin
                chk("w4_hold_pv", pv4, 1);
                chk("w4_hold_p", p4, prod);
                chk("w4_hold_pn", pn4, prod_n);
            end
        end
        ack4 = 1'b1;
        step();
        ack4 = 1'b0;
        chk("w4_done", done4, 1);
        chk("w4_busy", busy4, 0);
        chk("w4_p_null", p4, 0);
        step();
        chk("w4_done_clear", done4, 0);
        chk("w4_idle_busy", busy4, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb, flip;
        rst_n = 1'b0;
        s8 = 1'b0; ack8 = 1'b0; set8('0, '0);
        s4 = 1'b0; ack4 = 1'b0; set4('0, '0);
        step();
        step();
        chk("rst_busy", busy8, 0);
        chk("rst_pv", pv8, 0);
        chk("rst_p", p8, 0);
        chk("rst_pn", pn8, 0);
        chk("rst_done", done8, 0);
        chk("rst_rail", re8, 0);
        chk("rst_uerr", ue8, 0);
        chk("rst4_busy", busy4, 0);
        chk("rst4_pn", pn4, 0);
        rst_n = 1'b1;
        step();

        run8(8'd13, 8'd11, 0);
        step();
        chk("done_one_cycle", done8, 0);
        run8(8'd255, 8'd255, 5);
        step();

        rail8(8'd5, 8'hFB, 8'd3, 8'hFC);
        for (int i = 0; i < 4; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            flip = 8'h01 << $urandom_range(0, 7);
            if (i[0]) rail8(ra, ~ra, rb, ~rb ^ flip);
            else      rail8(ra, ~ra ^ flip, rb, ~rb);
        end

        // reset in the middle of FWD, then a clean run
        set8(8'd200, 8'd77);
        s8 = 1'b1;
        step();
        s8 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", busy8, 0);
        chk("midrst_pv", pv8, 0);
        chk("midrst_p", p8, 0);
        chk("midrst_pn", pn8, 0);
        chk("midrst_done", done8, 0);
        step();
        chk("midrst_idle", busy8, 0);
        run8(8'd3, 8'd7, 0);

        // back-to-back: each new start lands in the done cycle
        run8(8'd0, 8'd255, 1);
        run8(8'd255, 8'd0, 0);
        for (int i = 0; i < 8; i++)
            run8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        step();
        chk("final_done_clear", done8, 0);

        run4(4'd15, 4'd15);
        for (int i = 0; i < 4; i++) run4(4'($urandom), 4'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rev_mult_seq.md
Name: rev_mult_seq

Overview:
Parametrised sequential radix-2 shift-add multiplier with dual-rail operands and dual-rail product. It is the clocked successor to the 8-bit combinational reversible multiplier. It runs Bennett-style: a forward phase computes the product and holds it for the consumer, then a backward phase uncomputes the accumulator to zero rather than clearing it. The block sits between the dual-rail operand register file and the PE accumulate stage.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
UNCOMPUTE, 1, 1 = backward uncompute phase after ack; 0 = accumulator cleared in one cycle after ack.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  request; sampled only in IDLE.
a  in  WIDTH  multiplicand, true rail.
a_not  in  WIDTH  multiplicand, complement rail.
b  in  WIDTH  multiplier, true rail.
b_not  in  WIDTH  multiplier, complement rail.
p_ack  in  1  consumer has taken product; sampled only in HOLD.
busy  out  1  high in every state except IDLE.
p_valid  out  1  high exactly while in HOLD.
p  out  2*WIDTH  product, true rail.
p_not  out  2*WIDTH  product, complement rail.
done  out  1  one-cycle pulse on return to IDLE.
rail_err  out  1  one-cycle pulse when a start is rejected for an operand rail mismatch.
uncompute_err  out  1  sticky; accumulator was nonzero at the end of BWD; cleared by the next accepted start.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. rst_n=0 at an edge puts the block in IDLE with acc=0 and idx=0, and drives every output to 0 (p and p_not both all-zero). This applies mid-operation too; no partial result is exposed.
- States: IDLE, FWD, HOLD, BWD. Registers: a_r and b_r (WIDTH each), acc (2*WIDTH), idx (clog2(WIDTH) bits).
- Dual-rail NULL convention: p=acc and p_not=~acc only in HOLD. In every other state both p and p_not are all-zero.
- IDLE, start=1 and rails valid (a_not==~a and b_not==~b): capture a_r and b_r, set idx=0, clear uncompute_err, go to FWD.
- IDLE, start=1 and a rail mismatch: start is rejected, state stays IDLE, rail_err pulses in the next cycle.
- FWD, each edge: if b_r[idx]=1 then acc += a_r<<idx; idx++. The edge that processes idx=WIDTH-1 moves the block to HOLD. FWD therefore takes exactly WIDTH edges.
- Latency: if start is accepted at edge t, p_valid is high from cycle t+WIDTH+1.
- HOLD: outputs are stable indefinitely until p_ack=1.
- HOLD with p_ack=1 and UNCOMPUTE=1: idx=WIDTH-1, go to BWD.
- HOLD with p_ack=1 and UNCOMPUTE=0: acc=0, go to IDLE, done pulses.
- BWD, each edge: if b_r[idx]=1 then acc -= a_r<<idx; idx--. The edge that processes idx=0 moves the block to IDLE, pulses done, and sets uncompute_err if the resulting acc!=0. BWD takes exactly WIDTH edges.
- Arithmetic is modulo 2^(2*WIDTH). FWD never overflows for unsigned operands, and BWD exactly inverts FWD.
- start while busy: ignored, no error.
- p_ack outside HOLD: ignored.
- start and p_ack together in HOLD: ack is processed, start is ignored.
- start on the same cycle done is asserted: block is already in IDLE, so start is accepted normally.
- a_r and b_r are held unchanged from capture to the end of BWD. Input changes while busy have no effect.

Decomposition:
- Package rev_mult_pkg: state enum (IDLE, FWD, HOLD, BWD), localparam PW=2*WIDTH, and the idx width function.
- Sub-module dual_rail_check (parameter N): combinational, outputs ok = &(x ^ x_not). Instantiated once per operand.

Test Plan:
- WIDTH=8: a=13, b=11, start, p_ack asserted when p_valid rises -> p_valid first high 9 cycles after the start edge; p=0x008F, p_not=0xFF70; done 8 cycles after ack; uncompute_err=0.
- WIDTH=8: a=255, b=255, p_ack held 5 cycles late -> p=0xFE01 stable through HOLD; p and p_not both 0x0000 in all non-HOLD cycles.
- a=5 with a_not=0xFB (bit 0 wrong), start -> no state change; rail_err=1 for one cycle; busy=0.
- Start accepted, then start pulsed with a=1, b=1 at FWD cycle 3 -> ignored; final p equals the first operands' product.
- rst_n=0 at FWD cycle 4, then a new start with a=3, b=7 -> busy=0 the cycle after reset; new run gives p=21, no stale bits.
- WIDTH=4, UNCOMPUTE=0: a=15, b=15 -> p=0xE1 after 5 cycles; p_ack -> done the next cycle; busy low after that.
